// File: rtl/ram_arb_pkg.sv
// ============================================================================
//  ram_arb_pkg - shared types and the round-robin pick function for the RAM arbiter
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

  // One-hot grant for the first set bit of valid, searching upward from ptr, wrapping at num.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 num);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 pos;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = (int'(ptr) + k) % num;
      if (k < num && !found && valid[pos[PTR_W-1:0]]) begin
        grant[pos[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_onehot.sv
// ============================================================================
//  rr_pick_onehot - combinational rotate-priority encoder producing a one-hot grant
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick_onehot
  import ram_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] grant_ext;

  assign valid_ext = MAX_REQ'(valid);
  assign grant_ext = rr_pick(valid_ext, PTR_W'(ptr), N);
  assign grant     = grant_ext[N-1:0];

  // Bits above N can never be set because the search wraps at N.
  if (N < MAX_REQ) begin : g_pad
    logic unused_hi;
    assign unused_hi = |grant_ext[MAX_REQ-1:N];
  end

endmodule

`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
// ============================================================================
//  ram_rr_arbiter - round-robin arbiter sharing one write/read RAM among requesters
//  Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = `ADDR_BITS,
  parameter int DATA_W   = `DATA_BITS,
  parameter int MAX_LOCK = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr_write,
  output logic [DATA_W-1:0]         ram_data_write,
  output logic [ADDR_W-1:0]         ram_addr_read,
  input  logic [DATA_W-1:0]         ram_data_read
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   lock_cnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic [ADDR_W-1:0]  gaddr;
  logic [DATA_W-1:0]  gwdata;
  logic               xfer;
  logic               xfer_wr;
  logic               xfer_lock;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] n;
    if (int'(i) == NUM_REQ - 1) n = '0;
    else                        n = i + 1'b1;
    return n;
  endfunction

  rr_pick_onehot #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant)
  );

  always_comb begin
    grant = arb_grant;
    if (state == LOCK) begin
      grant        = '0;
      grant[owner] = req_valid[owner];
    end
  end

  always_comb begin
    gidx   = '0;
    gaddr  = '0;
    gwdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx   = IDX_W'(i);
        gaddr  = req_addr[i*ADDR_W +: ADDR_W];
        gwdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer      = |grant;
  assign xfer_wr   = |(grant & req_write);
  assign xfer_lock = |(grant & req_lock);

  assign req_ready      = grant;
  // Gate with reset so a write presented while reset is held never reaches the RAM.
  assign ram_we         = xfer_wr & reset_n;
  assign ram_addr_write = gaddr;
  assign ram_data_write = gwdata;
  assign ram_addr_read  = gaddr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      owner      <= '0;
      lock_cnt   <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= grant & ~req_write;
      if (xfer && !xfer_wr) resp_rdata <= ram_data_read;

      case (state)
        ARB: begin
          if (xfer) begin
            if (xfer_lock && MAX_LOCK > 1) begin
              state    <= LOCK;
              owner    <= gidx;
              lock_cnt <= CNT_W'(1);
            end else begin
              rr_ptr <= next_idx(gidx);
            end
          end
        end
        LOCK: begin
          // Owner leaves on unlock, on hitting the burst limit, or by dropping valid.
          if (xfer && xfer_lock && int'(lock_cnt) < MAX_LOCK - 1) begin
            lock_cnt <= lock_cnt + 1'b1;
          end else begin
            state    <= ARB;
            rr_ptr   <= next_idx(owner);
            lock_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
// ============================================================================
//  tb_ram_rr_arbiter - directed scoreboard bench for ram_rr_arbiter (NUM_REQ=2)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_rr_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int MAX_LOCK = 4;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req_valid, req_write, req_lock;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_ready, resp_valid;
  logic [7:0]  resp_rdata;
  logic        ram_we;
  logic [7:0]  ram_addr_write, ram_data_write, ram_addr_read, ram_data_read;

  typedef struct {
    logic [1:0] ready;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] resp_valid;
    logic [7:0] rdata;
  } exp_t;

  exp_t       cyc_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic [1:0] pend_valid;
  logic [7:0] pend_data;

  ram_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_lock       (req_lock),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .ram_we         (ram_we),
    .ram_addr_write (ram_addr_write),
    .ram_data_write (ram_data_write),
    .ram_addr_read  (ram_addr_read),
    .ram_data_read  (ram_data_read)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Simple RAM: synchronous write, combinational read.
  always @(posedge clock) if (ram_we) mem[ram_addr_write] <= ram_data_write;
  assign ram_data_read = mem[ram_addr_read];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("req_ready",      32'(req_ready),      32'(e.ready));
      check("ram_we",         32'(ram_we),         32'(e.we));
      check("ram_addr_write", 32'(ram_addr_write), 32'(e.addr));
      check("ram_addr_read",  32'(ram_addr_read),  32'(e.addr));
      check("ram_data_write", 32'(ram_data_write), 32'(e.wdata));
      check("resp_valid",     32'(resp_valid),     32'(e.resp_valid));
      if (e.resp_valid != 2'b00) check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
    end
  end

  task automatic cyc(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] exp_rdy);
    exp_t       e;
    logic [7:0] ga, gd;
    @(posedge clock); #1;
    req_valid = v;
    req_write = w;
    req_lock  = l;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    ga = exp_rdy[1] ? a1 : (exp_rdy[0] ? a0 : 8'h00);
    gd = exp_rdy[1] ? d1 : (exp_rdy[0] ? d0 : 8'h00);
    e.ready      = exp_rdy;
    e.we         = |(exp_rdy & w);
    e.addr       = ga;
    e.wdata      = gd;
    e.resp_valid = pend_valid;
    e.rdata      = pend_data;
    cyc_q.push_back(e);
    pend_valid = exp_rdy & ~w;
    pend_data  = ref_mem[ga];
    if (e.we) ref_mem[ga] = gd;
  endtask

  task automatic idle(input logic [1:0] exp_rdy);
    cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, exp_rdy);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset_n    = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_lock   = '0;
    req_addr   = '0;
    req_wdata  = '0;
    pend_valid = '0;
    pend_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_req_ready",  32'(req_ready),  0);
    check("reset_resp_valid", 32'(resp_valid), 0);
    check("reset_resp_rdata", 32'(resp_rdata), 0);
    check("reset_ram_we",     32'(ram_we),     0);
    reset_n = 1'b1;

    // Write then read-after-write to the same address.
    cyc(2'b01, 2'b01, 2'b00, 8'h05, 8'h00, 8'hA5, 8'h00, 2'b01);  // ptr -> 1
    cyc(2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00, 2'b10);  // ptr -> 0

    // Continuous reads from both requesters alternate.
    cyc(2'b01, 2'b01, 2'b00, 8'h06, 8'h00, 8'h3C, 8'h00, 2'b01);  // ptr -> 1
    cyc(2'b10, 2'b10, 2'b00, 8'h00, 8'h07, 8'h00, 8'hC3, 2'b10);  // ptr -> 0
    for (int k = 0; k < 4; k++)
      cyc(2'b11, 2'b00, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00, (k % 2 == 0) ? 2'b01 : 2'b10);

    // Idle cycles leave the pointer at 0; a lone requester is granted at once.
    idle(2'b00);
    idle(2'b00);
    cyc(2'b11, 2'b00, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00, 2'b01);  // ptr -> 1
    idle(2'b00);
    cyc(2'b01, 2'b00, 2'b00, 8'h06, 8'h00, 8'h00, 8'h00, 2'b01);  // ptr -> 1
    cyc(2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 8'h00, 8'h00, 2'b10);  // ptr -> 0

    // Locked burst capped at MAX_LOCK grants, then req0, then req1 again.
    cyc(2'b01, 2'b00, 2'b00, 8'h06, 8'h00, 8'h00, 8'h00, 2'b01);  // ptr -> 1
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);  // forced release, ptr -> 0
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b01);  // ptr -> 1
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);  // LOCK, owner 1

    // Owner drops valid: no grant that cycle, pointer moves past owner.
    cyc(2'b01, 2'b00, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00, 2'b00);  // ptr -> 0
    cyc(2'b11, 2'b00, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00, 2'b01);  // ptr -> 1

    // Owner unlocks voluntarily.
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);  // LOCK
    cyc(2'b11, 2'b00, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);  // release, ptr -> 0
    cyc(2'b11, 2'b00, 2'b00, 8'h06, 8'h07, 8'h00, 8'h00, 2'b01);  // ptr -> 1

    // Reset asserted mid-burst with a read response due and a write presented.
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);  // LOCK
    cyc(2'b11, 2'b00, 2'b10, 8'h06, 8'h07, 8'h00, 8'h00, 2'b10);
    @(posedge clock); #1;
    reset_n   = 1'b0;
    req_valid = 2'b01;
    req_write = 2'b01;
    req_lock  = 2'b00;
    req_addr  = {8'h00, 8'h09};
    req_wdata = {8'h00, 8'h77};
    pend_valid = '0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 0);
    check("midrst_ram_we",     32'(ram_we),     0);
    @(posedge clock); #1;
    check("midrst_ram_we_hold", 32'(ram_we), 0);
    req_valid = '0;
    req_write = '0;
    reset_n   = 1'b1;

    // After reset the lock is gone and req0 wins; address 9 was never written.
    cyc(2'b11, 2'b00, 2'b00, 8'h09, 8'h07, 8'h00, 8'h00, 2'b01);
    cyc(2'b10, 2'b00, 2'b00, 8'h00, 8'h09, 8'h00, 8'h00, 2'b10);
    idle(2'b00);
    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(cyc_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
